// File: rtl/voxel_region_reader.sv
// Walks an inclusive voxel box over a 1R memory and streams voxel words with coordinates.
// Define VOXEL_READER_SKIP_EMPTY_EN to drop all-zero words (out_last is then tied low).
module voxel_region_reader #(
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned COORD_WIDTH = 6,
   parameter int unsigned ADDR_WIDTH  = 18
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [COORD_WIDTH-1:0] cmd_x0,
   input  logic [COORD_WIDTH-1:0] cmd_y0,
   input  logic [COORD_WIDTH-1:0] cmd_z0,
   input  logic [COORD_WIDTH-1:0] cmd_x1,
   input  logic [COORD_WIDTH-1:0] cmd_y1,
   input  logic [COORD_WIDTH-1:0] cmd_z1,
   output logic [ADDR_WIDTH-1:0]  mem_read_addr,
   output logic                   mem_read_en,
   input  logic [DATA_WIDTH-1:0]  mem_read_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic [COORD_WIDTH-1:0] out_x,
   output logic [COORD_WIDTH-1:0] out_y,
   output logic [COORD_WIDTH-1:0] out_z,
   output logic                   out_last,
   output logic                   done,
   output logic                   err
);

   typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]  data;
      logic [COORD_WIDTH-1:0] x;
      logic [COORD_WIDTH-1:0] y;
      logic [COORD_WIDTH-1:0] z;
      logic                   last;
   } beat_t;

   state_e state_q, state_d;

   logic [COORD_WIDTH-1:0] x0_q, y0_q, z0_q, x1_q, y1_q, z1_q;
   logic [COORD_WIDTH-1:0] x_q, y_q, z_q;
   logic [COORD_WIDTH-1:0] tag_x_q, tag_y_q, tag_z_q;
   logic                   tag_last_q;
   logic                   inflight_q;

   beat_t       fifo_q [2];
   beat_t       head;
   logic        wr_ptr_q, rd_ptr_q;
   logic [1:0]  count_q, count_d;

   logic done_q, done_d, err_q, err_d;

   logic       cmd_fire, box_ok, pop, push, issue, last_issue, credit_ok;
   logic [2:0] occupancy;

   assign cmd_fire   = cmd_valid && (state_q == StIdle);
   assign box_ok     = (cmd_x0 <= cmd_x1) && (cmd_y0 <= cmd_y1) && (cmd_z0 <= cmd_z1);
   assign out_valid  = (count_q != 2'd0);
   assign pop        = out_valid && out_ready;
   assign last_issue = (x_q == x1_q) && (y_q == y1_q) && (z_q == z1_q);

   // Slots held = FIFO entries plus the read still in flight; a same-cycle pop frees one.
   assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
   assign credit_ok = occupancy < (3'd2 + {2'b00, pop});
   assign issue     = (state_q == StScan) && credit_ok;

   assign head = fifo_q[rd_ptr_q];

`ifdef VOXEL_READER_SKIP_EMPTY_EN
   assign push     = inflight_q && (mem_read_data != '0);
   assign out_last = 1'b0;
`else
   assign push     = inflight_q;
   assign out_last = out_valid && head.last;
`endif

   assign count_d  = count_q + {1'b0, push} - {1'b0, pop};
   assign out_data = head.data;
   assign out_x    = head.x;
   assign out_y    = head.y;
   assign out_z    = head.z;
   assign done     = done_q;
   assign err      = err_q;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cmd_fire && box_ok) begin
               state_d = StScan;
            end else if (cmd_fire) begin
               err_d = 1'b1;
            end
         end
         StScan: begin
            if (issue && last_issue) state_d = StDrain;
         end
         StDrain: begin
            // No reads issue here, so an empty FIFO next cycle means nothing is left.
            if (count_d == 2'd0) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      cmd_ready     = (state_q == StIdle);
      mem_read_en   = issue;
      mem_read_addr = issue ? ADDR_WIDTH'({x_q, y_q, z_q}) : '0;
   end

   // Bounds, scan counters and read tag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x0_q       <= '0;
         y0_q       <= '0;
         z0_q       <= '0;
         x1_q       <= '0;
         y1_q       <= '0;
         z1_q       <= '0;
         x_q        <= '0;
         y_q        <= '0;
         z_q        <= '0;
         tag_x_q    <= '0;
         tag_y_q    <= '0;
         tag_z_q    <= '0;
         tag_last_q <= 1'b0;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= issue;
         if (cmd_fire && box_ok) begin
            x0_q <= cmd_x0;
            y0_q <= cmd_y0;
            z0_q <= cmd_z0;
            x1_q <= cmd_x1;
            y1_q <= cmd_y1;
            z1_q <= cmd_z1;
            x_q  <= cmd_x0;
            y_q  <= cmd_y0;
            z_q  <= cmd_z0;
         end else if (issue && !last_issue) begin
            if (z_q == z1_q) begin
               z_q <= z0_q;
               if (y_q == y1_q) begin
                  y_q <= y0_q;
                  x_q <= x_q + 1'b1;
               end else begin
                  y_q <= y_q + 1'b1;
               end
            end else begin
               z_q <= z_q + 1'b1;
            end
         end
         if (issue) begin
            tag_x_q    <= x_q;
            tag_y_q    <= y_q;
            tag_z_q    <= z_q;
            tag_last_q <= last_issue;
         end
      end
   end

   // Two-entry output FIFO
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= '{data: mem_read_data, x: tag_x_q, y: tag_y_q, z: tag_z_q,
                                  last: tag_last_q};
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_d;
      end
   end

endmodule
